// File: rtl/jls_pkg.sv
// Shared widths and state encoding for the uh_jls frame sequencer and its beat counter.
package jls_pkg;
  localparam int W_BITS       = 11;
  localparam int H_BITS       = 16;
  localparam int PIX_BITS     = 8;
  localparam int PIX_PER_BEAT = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SOF   = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_GAP   = 3'd4
  } state_t;
endpackage

// File: rtl/jls_beat_counter.sv
// Column/row position of the current beat within a frame; flags the final beat.
module jls_beat_counter
  import jls_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [W_BITS-1:0] w_max,
  input  logic [H_BITS-1:0] h_max,
  output logic              last
);
  logic [W_BITS-1:0] col_q, col_d;
  logic [H_BITS-1:0] row_q, row_d;

  assign last = (col_q == w_max) && (row_q == h_max);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (col_q == w_max) begin
        col_d = '0;
        row_d = row_q + H_BITS'(1);
      end else begin
        col_d = col_q + W_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end
endmodule

// File: rtl/jls_frame_sequencer.sv
// Frame-level controller ahead of uh_jls: one frame in flight, zero-latency pixel pass-through,
// drain watchdog and an enforced idle gap after each frame.
//   state   | meaning
//   IDLE    | waiting for a frame descriptor
//   SOF     | single-cycle start-of-frame to the encoder
//   FEED    | pixel beats pass straight through, throttled by enc_rdy
//   DRAIN   | all beats sent, waiting for encoder o_last (watchdog running)
//   GAP     | enforced quiet time before the next frame
module jls_frame_sequencer
  import jls_pkg::*;
#(
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 1 << 20,
  parameter int CNT_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [W_BITS-1:0]              cmd_w,
  input  logic [H_BITS-1:0]              cmd_h,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  input  logic [PIX_BITS*PIX_PER_BEAT-1:0] pix_data,
  output logic                           enc_sof,
  output logic [W_BITS-1:0]              enc_w,
  output logic [H_BITS-1:0]              enc_h,
  input  logic                           enc_rdy,
  output logic                           enc_e,
  output logic [PIX_BITS-1:0]            enc_x0,
  output logic [PIX_BITS-1:0]            enc_x1,
  output logic [PIX_BITS-1:0]            enc_x2,
  output logic [PIX_BITS-1:0]            enc_x3,
  output logic [PIX_BITS-1:0]            enc_x4,
  input  logic                           enc_o_e,
  input  logic                           enc_o_last,
  output logic                           busy,
  output logic                           frame_done,
  output logic [CNT_W-1:0]               frame_cnt,
  output logic                           timeout
);
  // One down-counter serves both the drain watchdog and the gap timer.
  localparam int TMR_W = $clog2((TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES) + 1;
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);

  state_t            state_q, state_d;
  logic [W_BITS-1:0] w_q, w_d;
  logic [H_BITS-1:0] h_q, h_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              in_feed, beat_fire, beat_last, o_last_hit, bc_clr;

  assign in_feed    = (state_q == S_FEED);
  assign beat_fire  = in_feed & pix_valid & enc_rdy;
  assign o_last_hit = enc_o_e & enc_o_last;
  assign bc_clr     = (state_q == S_IDLE) & cmd_valid;

  jls_beat_counter u_beat_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (bc_clr),
    .en    (beat_fire),
    .w_max (w_q),
    .h_max (h_q),
    .last  (beat_last)
  );

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    cmd_ready = 1'b0;
    enc_sof   = 1'b0;
    pix_ready = 1'b0;
    enc_e     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_d     = cmd_w;
          h_d     = cmd_h;
          state_d = S_SOF;
        end
      end
      S_SOF: begin
        enc_sof = 1'b1;
        state_d = S_FEED;
      end
      S_FEED: begin
        pix_ready = enc_rdy;
        enc_e     = beat_fire;
        // An early o_last still completes the frame; remaining pixels are refused.
        if (o_last_hit) begin
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          tmr_d   = GAP_LOAD;
          state_d = S_GAP;
        end else if (beat_fire && beat_last) begin
          tmr_d   = TMO_LOAD;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (o_last_hit) begin
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          tmr_d   = GAP_LOAD;
          state_d = S_GAP;
        end else if (tmr_q == '0) begin
          tmo_d   = 1'b1;
          tmr_d   = GAP_LOAD;
          state_d = S_GAP;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_GAP: begin
        if (tmr_q == '0) state_d = S_IDLE;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  assign enc_w      = w_q;
  assign enc_h      = h_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;
  assign frame_cnt  = cnt_q;
  assign timeout    = tmo_q;
  assign enc_x0     = in_feed ? pix_data[0*PIX_BITS +: PIX_BITS] : '0;
  assign enc_x1     = in_feed ? pix_data[1*PIX_BITS +: PIX_BITS] : '0;
  assign enc_x2     = in_feed ? pix_data[2*PIX_BITS +: PIX_BITS] : '0;
  assign enc_x3     = in_feed ? pix_data[3*PIX_BITS +: PIX_BITS] : '0;
  assign enc_x4     = in_feed ? pix_data[4*PIX_BITS +: PIX_BITS] : '0;
endmodule
